// File: rtl/pgs_pkg.sv
// Shared types and constants for the single-pixel-imaging pattern/gate sequencer.
package pgs_pkg;

    localparam int unsigned SETTLE_CYC_DEF = 500;
    localparam int unsigned FLUSH_CYC      = 2;
    localparam int unsigned IDX_W_DEF      = 16;
    localparam int unsigned DW_W_DEF       = 32;
    localparam int unsigned CNT_W          = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADV,
        ST_SETTLE,
        ST_GATE,
        ST_FLUSH,
        ST_LATCH,
        ST_OUT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; expire_c is high during the last cycle of a loaded interval.
module dwell_timer
#(
    parameter int unsigned W = 32
) (
    input  logic         clk50Mhz,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire_c
);

    logic [W-1:0] remain;

    // A loaded value N keeps expire_c low for N-1 cycles, then high for exactly one.
    always_ff @(posedge clk50Mhz) begin
        if (rst) begin
            remain <= '0;
        end else if (load) begin
            remain <= load_val;
        end else if (remain != '0) begin
            remain <= remain - W'(1);
        end
    end

    assign expire_c = (remain == W'(1));

endmodule

// File: rtl/pattern_gate_sequencer.sv
// Per-frame sequencer: steps the DMD, settles, gates the photon counter for a dwell
// window, latches the count and hands (index, count) downstream over valid/ready.
module pattern_gate_sequencer
    import pgs_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned IDX_W      = IDX_W_DEF,
    parameter int unsigned DW_W       = DW_W_DEF
) (
    input  logic             clk50Mhz,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] num_pat,
    input  logic [DW_W-1:0]  dwell,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             cnt_sig,
    output logic             cnt_clr,
    output logic             pat_step,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_cnt
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] np_lat;
    logic [DW_W-1:0]  dwell_lat;

    logic             tmr_load_c;
    logic [DW_W-1:0]  tmr_val_c;
    logic             tmr_expire_c;
    logic             gate_open_c;

    assign gate_open_c = (state == ST_GATE);

    // One timer serves SETTLE, GATE and FLUSH; each is loaded on the edge entering it.
    always_comb begin
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
        case (state)
            ST_ADV: begin
                tmr_load_c = 1'b1;
                tmr_val_c  = DW_W'(SETTLE_CYC);
            end
            ST_SETTLE: begin
                if (tmr_expire_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = dwell_lat;
                end
            end
            ST_GATE: begin
                if (tmr_expire_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = DW_W'(FLUSH_CYC);
                end
            end
            default: begin
            end
        endcase
    end

    dwell_timer #(
        .W (DW_W)
    ) u_timer (
        .clk50Mhz (clk50Mhz),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .expire_c (tmr_expire_c)
    );

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk50Mhz) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt_clr   <= 1'b1;
            cnt_sig   <= 1'b0;
            pat_step  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_cnt   <= '0;
            idx       <= '0;
            np_lat    <= '0;
            dwell_lat <= '0;
        end else if (abort && (state != ST_IDLE)) begin
            state     <= ST_IDLE;
            cnt_clr   <= 1'b1;
            cnt_sig   <= 1'b0;
            pat_step  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            pat_step <= 1'b0;
            done     <= 1'b0;
            cnt_sig  <= sig_in & gate_open_c;
            case (state)
                ST_IDLE: begin
                    if (start && (num_pat != '0)) begin
                        np_lat    <= num_pat;
                        dwell_lat <= (dwell == '0) ? DW_W'(1) : dwell;
                        idx       <= '0;
                        busy      <= 1'b1;
                        pat_step  <= 1'b1;
                        state     <= ST_ADV;
                    end
                end
                ST_ADV: begin
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (tmr_expire_c) begin
                        cnt_clr <= 1'b0;
                        state   <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (tmr_expire_c) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (tmr_expire_c) begin
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    out_cnt   <= cnt_in;
                    out_idx   <= idx;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt_clr   <= 1'b1;
                        if (idx == (np_lat - IDX_W'(1))) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            idx      <= idx + IDX_W'(1);
                            pat_step <= 1'b1;
                            state    <= ST_ADV;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_gate_sequencer.sv
// Self-checking bench for pattern_gate_sequencer with a behavioural counter_32bit.
module tb_pattern_gate_sequencer;

    localparam int unsigned S  = 8;
    localparam int unsigned IW = 16;
    localparam int unsigned DW = 32;

    logic          clk50Mhz = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [IW-1:0] num_pat;
    logic [DW-1:0] dwell;
    logic          sig_in = 1'b0;
    logic [31:0]   cnt_in = 32'd0;
    logic          cnt_sig;
    logic          cnt_clr;
    logic          pat_step;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [31:0]   out_cnt;

    always #10 clk50Mhz = ~clk50Mhz;

    pattern_gate_sequencer #(
        .SETTLE_CYC (S),
        .IDX_W      (IW),
        .DW_W       (DW)
    ) dut (
        .clk50Mhz  (clk50Mhz),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .num_pat   (num_pat),
        .dwell     (dwell),
        .sig_in    (sig_in),
        .cnt_in    (cnt_in),
        .cnt_sig   (cnt_sig),
        .cnt_clr   (cnt_clr),
        .pat_step  (pat_step),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_cnt   (out_cnt)
    );

    // counter_32bit model
    always @(posedge clk50Mhz) begin
        if (cnt_clr) cnt_in <= 32'd0;
        else if (cnt_sig) cnt_in <= cnt_in + 32'd1;
    end

    // photon source, timed from the last pat_step (t=0 is the ADV cycle)
    bit          use_const = 1'b1;
    bit          sig_const = 1'b0;
    int          pre = 0;
    int          post = 0;
    int          deff = 1;
    logic [63:0] gmask = 64'd0;
    int          rel = 1000;

    function automatic logic sig_fn(input int r);
        int gs;
        gs = int'(S) + 1;
        if (use_const) return sig_const;
        if (r >= gs - pre && r < gs) return 1'b1;
        if (r >= gs && r < gs + deff) return gmask[r - gs];
        if (r >= gs + deff && r < gs + deff + post) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk50Mhz) begin
        if (pat_step === 1'b1) rel = 0;
        else if (rel < 1000) rel = rel + 1;
        sig_in = sig_fn(rel);
    end

    // event monitor
    int            n_step = 0;
    int            n_done = 0;
    logic [IW-1:0] hs_idx[$];
    logic [31:0]   hs_cnt[$];

    always @(posedge clk50Mhz) begin
        if (rst === 1'b0) begin
            if (pat_step === 1'b1) n_step = n_step + 1;
            if (done === 1'b1) n_done = n_done + 1;
            if (out_valid === 1'b1 && out_ready === 1'b1 && abort === 1'b0) begin
                hs_idx.push_back(out_idx);
                hs_cnt.push_back(out_cnt);
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk50Mhz);
    endtask

    task automatic start_frame(input int np, input int dw);
        start   = 1'b1;
        num_pat = IW'(np);
        dwell   = DW'(dw);
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_valid(input int bound, input string name);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(name, 64'(out_valid), 64'(1));
    endtask

    task automatic wait_done(input int bound, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(name, 64'(done), 64'(1));
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_ctl"}, 64'({cnt_clr, cnt_sig, pat_step, busy, done, out_valid}), 64'(6'b100000));
        chk({name, "_idx"}, 64'(out_idx), 64'(0));
        chk({name, "_cnt"}, 64'(out_cnt), 64'(0));
    endtask

    typedef struct {
        int          dw;
        int          dweff;
        logic [63:0] gmask;
        int          pre;
        int          post;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base_step;
        int base_done;
        int base_hs;
        logic [31:0] cnt0;
        bit bad;

        vecs[0] = '{dw: 10, dweff: 10, gmask: 64'h211,       pre: 5, post: 5, exp_cnt: 32'd3};
        vecs[1] = '{dw: 10, dweff: 10, gmask: 64'h3FF,       pre: 0, post: 0, exp_cnt: 32'd10};
        vecs[2] = '{dw: 0,  dweff: 1,  gmask: 64'h1,         pre: 3, post: 3, exp_cnt: 32'd1};
        vecs[3] = '{dw: 0,  dweff: 1,  gmask: 64'h0,         pre: 3, post: 3, exp_cnt: 32'd0};
        vecs[4] = '{dw: 16, dweff: 16, gmask: 64'h8001,      pre: 2, post: 4, exp_cnt: 32'd2};
        vecs[5] = '{dw: 1,  dweff: 1,  gmask: 64'h1,         pre: 0, post: 2, exp_cnt: 32'd1};
        vecs[6] = '{dw: 20, dweff: 20, gmask: 64'hAAAAA,     pre: 1, post: 1, exp_cnt: 32'd10};
        vecs[7] = '{dw: 64, dweff: 64, gmask: {64{1'b1}},    pre: 0, post: 0, exp_cnt: 32'd64};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        num_pat = '0; dwell = '0;
        tick(); tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // constant light, 3 patterns, dwell 100
        use_const = 1'b1; sig_const = 1'b1;
        base_step = n_step; base_hs = hs_idx.size();
        start_frame(3, 100);
        chk("t1_start_latency", 64'({pat_step, busy}), 64'(2'b11));
        repeat (S) tick();
        chk("t1_settle_clr", 64'({cnt_clr, cnt_sig}), 64'(2'b10));
        tick();
        chk("t1_gate0", 64'({cnt_clr, cnt_sig}), 64'(2'b00));
        tick();
        chk("t1_gate1_sig", 64'(cnt_sig), 64'(1));
        wait_done(3 * (int'(S) + 120), "t1_done");
        tick();
        chk("t1_busy_fall", 64'(busy), 64'(0));
        chk("t1_steps", 64'(n_step - base_step), 64'(3));
        chk("t1_results", 64'(hs_idx.size() - base_hs), 64'(3));
        for (int i = 0; i < 3; i++) begin
            if (base_hs + i < hs_idx.size()) begin
                chk("t1_idx", 64'(hs_idx[base_hs + i]), 64'(i));
                chk("t1_cnt", 64'(hs_cnt[base_hs + i]), 64'(100));
            end else begin
                chk("t1_missing_result", 64'(0), 64'(1));
            end
        end

        // table: single-pattern frames with shaped photon trains
        use_const = 1'b0;
        for (int v = 0; v < 8; v++) begin
            gmask = vecs[v].gmask;
            pre   = vecs[v].pre;
            post  = vecs[v].post;
            deff  = vecs[v].dweff;
            start_frame(1, vecs[v].dw);
            wait_valid(int'(S) + vecs[v].dweff + 20, "vec_valid");
            chk("vec_idx", 64'(out_idx), 64'(0));
            chk("vec_cnt", 64'(out_cnt), 64'(vecs[v].exp_cnt));
            wait_done(5, "vec_done");
            tick();
            chk("vec_idle", 64'(busy), 64'(0));
        end

        // backpressure: hold ready low 50 cycles on the first result
        use_const = 1'b1; sig_const = 1'b1;
        out_ready = 1'b0;
        start_frame(2, 7);
        wait_valid(int'(S) + 30, "t3_valid");
        cnt0 = out_cnt;
        chk("t3_first_cnt", 64'(cnt0), 64'(7));
        base_step = n_step;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_idx !== IW'(0) || out_cnt !== cnt0 || pat_step !== 1'b0) bad = 1'b1;
        end
        chk("t3_hold_stable", 64'(bad), 64'(0));
        chk("t3_no_step", 64'(n_step - base_step), 64'(0));
        out_ready = 1'b1;
        tick();
        chk("t3_step_after_hs", 64'({pat_step, out_valid}), 64'(2'b10));
        wait_valid(int'(S) + 30, "t3_valid2");
        chk("t3_idx2", 64'(out_idx), 64'(1));
        chk("t3_cnt2", 64'(out_cnt), 64'(7));
        wait_done(5, "t3_done");
        tick();

        // num_pat == 0 is ignored
        start_frame(0, 50);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0 || pat_step !== 1'b0) bad = 1'b1;
            tick();
        end
        chk("t4_zero_pat", 64'(bad), 64'(0));

        // abort in GATE of pattern 1 of 4
        start_frame(4, 10);
        wait_valid(int'(S) + 30, "t5_valid0");
        chk("t5_cnt0", 64'(out_cnt), 64'(10));
        for (int i = 0; i < 5 && pat_step !== 1'b1; i++) tick();
        chk("t5_step1", 64'(pat_step), 64'(1));
        repeat (S + 4) tick();
        chk("t5_in_gate", 64'({cnt_clr, out_valid}), 64'(2'b00));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort", 64'({busy, cnt_clr, out_valid, pat_step, done}), 64'(5'b01000));
        base_done = n_done;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid !== 1'b0 || done !== 1'b0 || pat_step !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("t5_quiet", 64'(bad), 64'(0));
        chk("t5_no_done", 64'(n_done - base_done), 64'(0));
        start_frame(1, 5);
        wait_valid(int'(S) + 30, "t5_restart_valid");
        chk("t5_restart_idx", 64'(out_idx), 64'(0));
        chk("t5_restart_cnt", 64'(out_cnt), 64'(5));
        wait_done(5, "t5_restart_done");
        tick();

        // start while busy is ignored, including new num_pat/dwell
        base_step = n_step; base_hs = hs_idx.size();
        start_frame(2, 5);
        tick(); tick(); tick();
        start = 1'b1; num_pat = IW'(7); dwell = DW'(40);
        tick();
        start = 1'b0;
        wait_done(2 * (int'(S) + 20) + 20, "t6_done");
        tick();
        chk("t6_steps", 64'(n_step - base_step), 64'(2));
        chk("t6_results", 64'(hs_idx.size() - base_hs), 64'(2));
        if (hs_cnt.size() > 0) chk("t6_last_cnt", 64'(hs_cnt[hs_cnt.size() - 1]), 64'(5));
        chk("t6_idle", 64'(busy), 64'(0));

        // rst while a result is waiting
        out_ready = 1'b0;
        start_frame(2, 6);
        wait_valid(int'(S) + 30, "t6_rst_valid");
        rst = 1'b1;
        tick();
        chk_reset_vals("t6_rst");
        rst = 1'b0;
        out_ready = 1'b1;
        base_done = n_done;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || pat_step !== 1'b0) bad = 1'b1;
        end
        chk("t6_rst_quiet", 64'(bad), 64'(0));
        chk("t6_rst_no_done", 64'(n_done - base_done), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
